exec_stage: RTL and testbench
=============================

// Module: exec_stage
// PURPOSE
//  Execute stage of the integer pipeline. Accepts one decoded instruction per cycle from issue.
//  Selects ALU operands and drives the combinational alu. Resolves branches/jumps.
//  Holds the result in a single registered slot that feeds writeback under valid/ready.
//  Flush input kills the held result and any instruction presented in the same cycle.
// PARAMETERS
//  RESET_PC_INC  4  link-address increment for JAL/JALR (pc + RESET_PC_INC)
// PORTS
//  clk_i           in   1   clock, rising edge
//  rst_n_i         in   1   reset, asynchronous assert, active-low
//  flush_i         in   1   kill held result and current input this cycle
//  valid_i         in   1   issue presents instruction
//  ready_o         out  1   stage can accept this cycle
//  alu_op_i        in   4   `ALU_* opcode
//  a_sel_i         in   1   0: rs1, 1: pc
//  b_sel_i         in   1   0: rs2, 1: imm
//  br_type_i       in   3   `BR_NONE/BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR
//  pc_i            in   32  instruction pc
//  rs1_i, rs2_i    in   32  register operands
//  imm_i           in   32  sign-extended immediate
//  rd_i            in   5   destination index
//  rd_we_i         in   1   destination write enable
//  wb_valid_o      out  1   result slot full
//  wb_ready_i      in   1   writeback consumes slot
//  wb_rd_o         out  5   registered rd
//  wb_we_o         out  1   registered rd_we (forced 0 when rd==0)
//  wb_data_o       out  32  registered result
//  redir_o         out  1   one-cycle pulse: taken branch/jump
//  redir_pc_o      out  32  redirect target
//  misalign_o      out  1   one-cycle pulse with redir_o when target[1]==1
// BEHAVIOUR
//  - Reset: all outputs 0; slot empty.
//  - Reset mid-operation drops the slot and any pending pulse immediately.
//  - ready_o = !wb_valid_o | wb_ready_i. Purely combinational; does not depend on valid_i.
//  - accept = valid_i & ready_o & !flush_i. On accept, the slot loads on the next edge: latency 1.
//  - Slot state:
//    - held while wb_valid_o & !wb_ready_i;
//    - cleared on wb_ready_i without accept;
//    - replaced on simultaneous consume+accept (full throughput).
//  - flush_i: slot cleared next edge. Beats consume and accept in the same cycle.
//    Suppresses redir_o/misalign_o for the input.
//  - Operands: A = a_sel ? pc : rs1; B = b_sel ? imm : rs2. All arithmetic is modulo 2^32.
//  - Branch compare (rs1 vs rs2) uses dedicated eq/lt/ltu logic, independent of alu_op_i.
//  - Taken conditions:
//    - BEQ eq; BNE !eq; BLT lt; BGE !lt; BLTU ltu; BGEU !ltu;
//    - JAL/JALR always; BR_NONE never.
//  - Targets:
//    - conditional branches and JAL: pc+imm;
//    - JALR: (rs1+imm) & ~32'h1.
//  - wb_data: JAL/JALR -> pc+RESET_PC_INC; otherwise alu result. Conditional branches set wb_we=0.
//  - redir_o/redir_pc_o/misalign_o: registered, asserted the edge after a taken accept,
//    deasserted the following edge. redir_pc_o holds its value when redir_o==0.
//  - Stall (slot full, !wb_ready_i): no accept, so no redirect.
//  - Wrap-around: pc+imm overflow wraps silently. pc 0xFFFF_FFFC with JAL link gives 0x0.
// STRUCTURE
//  - define.v (shared): `ALU_* codes (already present); add `BR_* 3-bit codes.
//  - One sub-module: alu (instantiated as u_alu); operand muxes feed it.
//  - Branch compare, target adder and output registers are local.
// TESTING
//  1 ADD: rs1=5, rs2=7, b_sel=0, rd=3 -> wb_valid=1 next cycle, wb_data=12, wb_rd=3, wb_we=1.
//  2 Backpressure: wb_ready=0 with slot full -> ready_o=0, slot stable;
//    wb_ready=1 with valid_i -> new result replaces old in one cycle.
//  3 BLT: rs1=0xFFFF_FFFF, rs2=1, pc=0x100, imm=0x20 -> redir_o pulse, redir_pc=0x120, wb_we=0;
//    same operands as BLTU -> no redirect.
//  4 JALR: rs1=0x203, imm=0, pc=0x40 -> redir_pc=0x202, misalign_o=1, wb_data=0x44.
//  5 Flush: flush_i with valid_i and full slot -> wb_valid=0 next edge, no redir_o.
//  6 Reset: rst_n_i low mid-stream with slot full and redirect pending
//    -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/exec_stage_pkg.sv
// Shared ALU opcodes, branch kinds, the writeback slot layout and the branch-taken decode.
// Nine branch kinds do not fit in three bits, so br_type is BR_W wide.
package exec_stage_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam int BR_W = 4;
    localparam logic [BR_W-1:0] BR_NONE = 4'd0;
    localparam logic [BR_W-1:0] BR_BEQ  = 4'd1;
    localparam logic [BR_W-1:0] BR_BNE  = 4'd2;
    localparam logic [BR_W-1:0] BR_BLT  = 4'd3;
    localparam logic [BR_W-1:0] BR_BGE  = 4'd4;
    localparam logic [BR_W-1:0] BR_BLTU = 4'd5;
    localparam logic [BR_W-1:0] BR_BGEU = 4'd6;
    localparam logic [BR_W-1:0] BR_JAL  = 4'd7;
    localparam logic [BR_W-1:0] BR_JALR = 4'd8;

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } wb_slot_t;

    function automatic logic br_taken(input logic [BR_W-1:0] br, input logic eq,
                                      input logic lt, input logic ltu);
        logic t;
        t = 1'b0;
        case (br)
            BR_BEQ:  t = eq;
            BR_BNE:  t = !eq;
            BR_BLT:  t = lt;
            BR_BGE:  t = !lt;
            BR_BLTU: t = ltu;
            BR_BGEU: t = !ltu;
            BR_JAL:  t = 1'b1;
            BR_JALR: t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/exec_stage_alu.sv
// Combinational integer ALU, zero latency, no flow control.
module exec_stage_alu
    import exec_stage_pkg::*;
(
    input  logic [3:0]  alu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    always_comb begin
        y = 32'd0;
        case (alu_op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_SLL:   y = a << b[4:0];
            ALU_SLT:   y = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:  y = {31'd0, a < b};
            ALU_XOR:   y = a ^ b;
            ALU_SRL:   y = a >> b[4:0];
            ALU_SRA:   y = 32'($signed(a) >>> b[4:0]);
            ALU_OR:    y = a | b;
            ALU_AND:   y = a & b;
            ALU_PASSB: y = b;
            default:   y = 32'd0;
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: operand select, ALU, branch resolve; one registered result slot, latency 1.
// Valid/ready toward writeback; ready_o is high whenever the slot is empty or being drained.
module exec_stage
    import exec_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC_INC = 32'd4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [3:0]      alu_op_i,
    input  logic            a_sel_i,
    input  logic            b_sel_i,
    input  logic [BR_W-1:0] br_type_i,
    input  logic [31:0]     pc_i,
    input  logic [31:0]     rs1_i,
    input  logic [31:0]     rs2_i,
    input  logic [31:0]     imm_i,
    input  logic [4:0]      rd_i,
    input  logic            rd_we_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [4:0]      wb_rd_o,
    output logic            wb_we_o,
    output logic [31:0]     wb_data_o,
    output logic            redir_o,
    output logic [31:0]     redir_pc_o,
    output logic            misalign_o
);

    logic [31:0] op_a, op_b, alu_y;
    logic [31:0] pc_tgt, jalr_sum, target, link;
    logic        eq, lt, ltu, taken, is_jump, is_cond, accept;
    wb_slot_t    slot_q, slot_d;

    assign op_a = a_sel_i ? pc_i : rs1_i;
    assign op_b = b_sel_i ? imm_i : rs2_i;

    exec_stage_alu u_alu (
        .alu_op (alu_op_i),
        .a      (op_a),
        .b      (op_b),
        .y      (alu_y)
    );

    // Branch compare is separate from the ALU so alu_op_i stays free for the link/address result.
    assign eq    = (rs1_i == rs2_i);
    assign lt    = ($signed(rs1_i) < $signed(rs2_i));
    assign ltu   = (rs1_i < rs2_i);
    assign taken = br_taken(br_type_i, eq, lt, ltu);

    assign is_jump  = (br_type_i == BR_JAL) || (br_type_i == BR_JALR);
    assign is_cond  = !is_jump && (br_type_i != BR_NONE);
    assign pc_tgt   = pc_i + imm_i;
    assign jalr_sum = rs1_i + imm_i;
    assign target   = (br_type_i == BR_JALR) ? (jalr_sum & ~32'h1) : pc_tgt;
    assign link     = pc_i + RESET_PC_INC;

    assign ready_o = !wb_valid_o || wb_ready_i;
    assign accept  = valid_i && ready_o && !flush_i;

    always_comb begin
        slot_d      = slot_q;
        slot_d.rd   = rd_i;
        slot_d.we   = rd_we_i && (rd_i != 5'd0) && !is_cond;
        slot_d.data = is_jump ? link : alu_y;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_valid_o <= 1'b0;
            slot_q     <= '0;
            redir_o    <= 1'b0;
            redir_pc_o <= 32'd0;
            misalign_o <= 1'b0;
        end else begin
            redir_o    <= accept && taken;
            misalign_o <= accept && taken && target[1];
            if (accept && taken) begin
                redir_pc_o <= target;
            end
            if (flush_i) begin
                wb_valid_o <= 1'b0;
            end else if (accept) begin
                wb_valid_o <= 1'b1;
                slot_q     <= slot_d;
            end else if (wb_ready_i) begin
                wb_valid_o <= 1'b0;
            end
        end
    end

    assign wb_rd_o   = slot_q.rd;
    assign wb_we_o   = slot_q.we;
    assign wb_data_o = slot_q.data;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: driver queues expected results, negedge monitor checks them.
module tb_exec_stage;
    import exec_stage_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            flush_i;
    logic            valid_i;
    logic            ready_o;
    logic [3:0]      alu_op_i;
    logic            a_sel_i;
    logic            b_sel_i;
    logic [BR_W-1:0] br_type_i;
    logic [31:0]     pc_i, rs1_i, rs2_i, imm_i;
    logic [4:0]      rd_i;
    logic            rd_we_i;
    logic            wb_valid_o;
    logic            wb_ready_i;
    logic [4:0]      wb_rd_o;
    logic            wb_we_o;
    logic [31:0]     wb_data_o;
    logic            redir_o;
    logic [31:0]     redir_pc_o;
    logic            misalign_o;

    typedef struct packed {
        logic [31:0] pc;
        logic        mis;
    } redir_t;

    int       n_checks = 0;
    int       n_fail   = 0;
    wb_slot_t wb_q[$];
    redir_t   redir_q[$];
    wb_slot_t m_wb;
    redir_t   m_rd;

    always #5 clk_i = ~clk_i;

    exec_stage #(.RESET_PC_INC(32'd4)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .alu_op_i   (alu_op_i),
        .a_sel_i    (a_sel_i),
        .b_sel_i    (b_sel_i),
        .br_type_i  (br_type_i),
        .pc_i       (pc_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .imm_i      (imm_i),
        .rd_i       (rd_i),
        .rd_we_i    (rd_we_i),
        .wb_valid_o (wb_valid_o),
        .wb_ready_i (wb_ready_i),
        .wb_rd_o    (wb_rd_o),
        .wb_we_o    (wb_we_o),
        .wb_data_o  (wb_data_o),
        .redir_o    (redir_o),
        .redir_pc_o (redir_pc_o),
        .misalign_o (misalign_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (wb_valid_o && wb_ready_i) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", {31'd0, wb_valid_o}, 32'd0);
                end else begin
                    m_wb = wb_q.pop_front();
                    check("wb_rd", {27'd0, wb_rd_o}, {27'd0, m_wb.rd});
                    check("wb_we", {31'd0, wb_we_o}, {31'd0, m_wb.we});
                    check("wb_data", wb_data_o, m_wb.data);
                end
            end
            if (redir_o) begin
                if (redir_q.size() == 0) begin
                    check("redir_unexpected", {31'd0, redir_o}, 32'd0);
                end else begin
                    m_rd = redir_q.pop_front();
                    check("redir_pc", redir_pc_o, m_rd.pc);
                    check("misalign", {31'd0, misalign_o}, {31'd0, m_rd.mis});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic as, input logic bs,
                         input logic [BR_W-1:0] br, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [4:0] rd, input logic we);
        alu_op_i = op; a_sel_i = as; b_sel_i = bs; br_type_i = br;
        pc_i = pc; rs1_i = r1; rs2_i = r2; imm_i = im;
        rd_i = rd; rd_we_i = we; valid_i = 1'b1;
    endtask

    // Issue one instruction expected to be accepted this cycle; queue its result and redirect.
    task automatic issue(input logic [3:0] op, input logic as, input logic bs,
                         input logic [BR_W-1:0] br, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [4:0] rd, input logic we,
                         input logic [31:0] exp_data, input logic exp_we,
                         input logic tk, input logic [31:0] tgt, input logic mis);
        drive(op, as, bs, br, pc, r1, r2, im, rd, we);
        check("ready_at_issue", {31'd0, ready_o}, 32'd1);
        wb_q.push_back('{rd: rd, we: exp_we, data: exp_data});
        if (tk) redir_q.push_back('{pc: tgt, mis: mis});
        step();
        valid_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wb_valid"}, {31'd0, wb_valid_o}, 32'd0);
        check({tag, "_wb_rd"}, {27'd0, wb_rd_o}, 32'd0);
        check({tag, "_wb_we"}, {31'd0, wb_we_o}, 32'd0);
        check({tag, "_wb_data"}, wb_data_o, 32'd0);
        check({tag, "_redir"}, {31'd0, redir_o}, 32'd0);
        check({tag, "_redir_pc"}, redir_pc_o, 32'd0);
        check({tag, "_misalign"}, {31'd0, misalign_o}, 32'd0);
    endtask

    initial begin
        rst_n_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; wb_ready_i = 1'b1;
        drive(ALU_ADD, 1'b0, 1'b0, BR_NONE, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        valid_i = 1'b0;
        #12;
        check_all_zero("reset");
        check("reset_ready", {31'd0, ready_o}, 32'd1);
        rst_n_i = 1'b1;
        step();

        // ALU datapath and operand selection
        issue(ALU_ADD,  0, 0, BR_NONE, 32'h0,    32'd5, 32'd7, 32'h0, 5'd3, 1, 32'd12, 1, 0, 32'h0, 0);
        issue(ALU_SLT,  0, 0, BR_NONE, 32'h0,    32'hFFFF_FFFF, 32'd1, 32'h0, 5'd11, 1, 32'd1, 1, 0, 32'h0, 0);
        issue(ALU_SLTU, 0, 0, BR_NONE, 32'h0,    32'hFFFF_FFFF, 32'd1, 32'h0, 5'd11, 1, 32'd0, 1, 0, 32'h0, 0);
        issue(ALU_SRA,  0, 1, BR_NONE, 32'h0,    32'h8000_0000, 32'd0, 32'd4, 5'd12, 1, 32'hF800_0000, 1, 0, 32'h0, 0);
        issue(ALU_SLL,  0, 1, BR_NONE, 32'h0,    32'd1, 32'd0, 32'd31, 5'd13, 1, 32'h8000_0000, 1, 0, 32'h0, 0);
        issue(ALU_ADD,  1, 1, BR_NONE, 32'h1000, 32'd0, 32'd0, 32'h10, 5'd14, 1, 32'h1010, 1, 0, 32'h0, 0);
        issue(ALU_ADD,  0, 0, BR_NONE, 32'h0,    32'd1, 32'd1, 32'h0, 5'd0, 1, 32'd2, 0, 0, 32'h0, 0);
        step();

        // Backpressure: slot held, then consume + accept in the same cycle
        wb_ready_i = 1'b0;
        issue(ALU_SUB, 0, 0, BR_NONE, 32'h0, 32'd20, 32'd6, 32'h0, 5'd4, 1, 32'd14, 1, 0, 32'h0, 0);
        check("bp_valid", {31'd0, wb_valid_o}, 32'd1);
        check("bp_ready", {31'd0, ready_o}, 32'd0);
        drive(ALU_XOR, 0, 0, BR_NONE, 32'h0, 32'hF0, 32'hFF, 32'h0, 5'd5, 1);
        for (int i = 0; i < 2; i++) begin
            step();
            check("bp_hold_data", wb_data_o, 32'd14);
            check("bp_hold_rd", {27'd0, wb_rd_o}, 32'd4);
            check("bp_hold_ready", {31'd0, ready_o}, 32'd0);
        end
        wb_ready_i = 1'b1;
        wb_q.push_back('{rd: 5'd5, we: 1'b1, data: 32'h0F});
        step();
        valid_i = 1'b0;
        check("bp_replace_data", wb_data_o, 32'h0F);
        check("bp_replace_rd", {27'd0, wb_rd_o}, 32'd5);
        step();

        // Branches and jumps
        issue(ALU_ADD, 1, 1, BR_BLT,  32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd7, 1, 32'h120, 0, 1, 32'h120, 0);
        issue(ALU_ADD, 1, 1, BR_BLTU, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd7, 1, 32'h120, 0, 0, 32'h0, 0);
        issue(ALU_ADD, 1, 1, BR_BGE,  32'h200, 32'd3, 32'd3, 32'hFFFF_FFFC, 5'd7, 1, 32'h1FC, 0, 1, 32'h1FC, 0);
        issue(ALU_ADD, 1, 1, BR_BNE,  32'h200, 32'd3, 32'd3, 32'hFFFF_FFFC, 5'd7, 1, 32'h1FC, 0, 0, 32'h0, 0);
        issue(ALU_ADD, 1, 1, BR_BEQ,  32'h300, 32'd8, 32'd8, 32'h12, 5'd7, 1, 32'h312, 0, 1, 32'h312, 1);
        issue(ALU_ADD, 1, 1, BR_BGEU, 32'h300, 32'd1, 32'hFFFF_FFFF, 32'h12, 5'd7, 1, 32'h312, 0, 0, 32'h0, 0);
        issue(ALU_ADD, 0, 1, BR_JALR, 32'h40, 32'h203, 32'd0, 32'h0, 5'd1, 1, 32'h44, 1, 1, 32'h202, 1);
        issue(ALU_ADD, 1, 1, BR_JAL,  32'hFFFF_FFFC, 32'd0, 32'd0, 32'h8, 5'd2, 1, 32'h0, 1, 1, 32'h4, 0);
        step();
        check("redir_pc_holds", redir_pc_o, 32'h4);
        step();

        // Flush kills the held slot and the presented jump
        wb_ready_i = 1'b0;
        issue(ALU_ADD, 0, 0, BR_NONE, 32'h0, 32'd1, 32'd2, 32'h0, 5'd6, 1, 32'd3, 1, 0, 32'h0, 0);
        drive(ALU_ADD, 1, 1, BR_JAL, 32'h80, 32'd0, 32'd0, 32'h10, 5'd8, 1);
        flush_i = 1'b1;
        void'(wb_q.pop_back());
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("flush_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        check("flush_redir", {31'd0, redir_o}, 32'd0);
        step();
        check("flush_redir_late", {31'd0, redir_o}, 32'd0);
        wb_ready_i = 1'b1;
        step();

        // Asynchronous reset with the slot full and a redirect pulse live
        wb_ready_i = 1'b0;
        issue(ALU_ADD, 1, 1, BR_JAL, 32'h1000, 32'd0, 32'd0, 32'h40, 5'd9, 1, 32'h1004, 1, 1, 32'h1040, 0);
        check("pre_reset_valid", {31'd0, wb_valid_o}, 32'd1);
        check("pre_reset_redir", {31'd0, redir_o}, 32'd1);
        #1 rst_n_i = 1'b0;
        #1;
        check_all_zero("async_reset");
        wb_q.delete();
        redir_q.delete();
        wb_ready_i = 1'b1;
        step();
        rst_n_i = 1'b1;
        step();

        issue(ALU_ADD, 0, 0, BR_NONE, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 5'd10, 1, 32'd0, 1, 0, 32'h0, 0);
        step();
        step();
        check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        check("redir_queue_drained", 32'(redir_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
